// File: rtl/ascii_to_scancode_if.sv
// Key-in / scan-byte-out handshake bundle for the Hack-code to PS/2 set-2 encoder.
// The slave view is the encoder itself; the master view is whatever feeds keys and sinks bytes.
interface ascii_to_scancode_if;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       scan_valid;
  logic       scan_ready;
  logic [7:0] scan_code;
  logic       unmapped;
  logic       busy;

  modport slave (
    input  key_valid, key_code, scan_ready,
    output key_ready, scan_valid, scan_code, unmapped, busy
  );

  modport master (
    output key_valid, key_code, scan_ready,
    input  key_ready, scan_valid, scan_code, unmapped, busy
  );
endinterface

// File: rtl/ascii_to_scancode.sv
// Encodes one Hack keyboard code into its PS/2 set-2 make (and optionally break) byte
// sequence, streamed out one byte per valid/ready transfer with optional idle gaps.
module ascii_to_scancode #(
  parameter bit          EMIT_BREAK = 1'b1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic               clk,
  input  logic               reset,
  ascii_to_scancode_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DROP} state_t;

  localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t     state_q, state_d;
  logic [7:0] seq_q [5];
  logic [7:0] seq_d [5];
  logic [2:0] len_q, len_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] gap_q, gap_d;

  logic       lk_hit;
  logic       lk_ext;
  logic [7:0] lk_code;

  // Inverse of the scan-code decoder table; keypad duplicates resolve to the main key.
  always_comb begin
    lk_hit  = 1'b1;
    lk_ext  = 1'b0;
    lk_code = 8'h00;
    case (bus.key_code)
      8'd9:   lk_code = 8'h0d;  8'd32:  lk_code = 8'h29;  8'd39:  lk_code = 8'h52;
      8'd42:  lk_code = 8'h7c;  8'd43:  lk_code = 8'h79;  8'd44:  lk_code = 8'h41;
      8'd45:  lk_code = 8'h4e;  8'd46:  lk_code = 8'h49;  8'd47:  lk_code = 8'h4a;
      8'd48:  lk_code = 8'h45;  8'd49:  lk_code = 8'h16;  8'd50:  lk_code = 8'h1e;
      8'd51:  lk_code = 8'h26;  8'd52:  lk_code = 8'h25;  8'd53:  lk_code = 8'h2e;
      8'd54:  lk_code = 8'h36;  8'd55:  lk_code = 8'h3d;  8'd56:  lk_code = 8'h3e;
      8'd57:  lk_code = 8'h46;  8'd58:  lk_code = 8'h4c;  8'd61:  lk_code = 8'h55;
      8'd91:  lk_code = 8'h54;  8'd92:  lk_code = 8'h5d;  8'd93:  lk_code = 8'h5b;
      8'd96:  lk_code = 8'h0e;
      8'd97:  lk_code = 8'h1c;  8'd98:  lk_code = 8'h32;  8'd99:  lk_code = 8'h21;
      8'd100: lk_code = 8'h23;  8'd101: lk_code = 8'h24;  8'd102: lk_code = 8'h2b;
      8'd103: lk_code = 8'h34;  8'd104: lk_code = 8'h33;  8'd105: lk_code = 8'h43;
      8'd106: lk_code = 8'h3b;  8'd107: lk_code = 8'h42;  8'd108: lk_code = 8'h4b;
      8'd109: lk_code = 8'h3a;  8'd110: lk_code = 8'h31;  8'd111: lk_code = 8'h44;
      8'd112: lk_code = 8'h4d;  8'd113: lk_code = 8'h15;  8'd114: lk_code = 8'h2d;
      8'd115: lk_code = 8'h1b;  8'd116: lk_code = 8'h2c;  8'd117: lk_code = 8'h3c;
      8'd118: lk_code = 8'h2a;  8'd119: lk_code = 8'h1d;  8'd120: lk_code = 8'h22;
      8'd121: lk_code = 8'h35;  8'd122: lk_code = 8'h1a;
      8'd128: lk_code = 8'h5a;  8'd129: lk_code = 8'h66;  8'd140: lk_code = 8'h76;
      8'd130: begin lk_code = 8'h6b; lk_ext = 1'b1; end
      8'd131: begin lk_code = 8'h75; lk_ext = 1'b1; end
      8'd132: begin lk_code = 8'h74; lk_ext = 1'b1; end
      8'd133: begin lk_code = 8'h72; lk_ext = 1'b1; end
      8'd134: begin lk_code = 8'h6c; lk_ext = 1'b1; end
      8'd135: begin lk_code = 8'h69; lk_ext = 1'b1; end
      8'd136: begin lk_code = 8'h7d; lk_ext = 1'b1; end
      8'd137: begin lk_code = 8'h7a; lk_ext = 1'b1; end
      8'd138: begin lk_code = 8'h70; lk_ext = 1'b1; end
      8'd139: begin lk_code = 8'h71; lk_ext = 1'b1; end
      8'd141: lk_code = 8'h05;  8'd142: lk_code = 8'h06;  8'd143: lk_code = 8'h04;
      8'd144: lk_code = 8'h0c;  8'd145: lk_code = 8'h03;  8'd146: lk_code = 8'h0b;
      8'd147: lk_code = 8'h83;  8'd148: lk_code = 8'h0a;  8'd149: lk_code = 8'h01;
      8'd150: lk_code = 8'h09;  8'd151: lk_code = 8'h78;  8'd152: lk_code = 8'h07;
      default: lk_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    len_d   = len_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (bus.key_valid) begin
          if (!lk_hit) begin
            state_d = DROP;
          end else begin
            state_d = SEND;
            idx_d   = 3'd0;
            if (lk_ext) begin
              seq_d[0] = 8'he0;
              seq_d[1] = lk_code;
              seq_d[2] = 8'he0;
              seq_d[3] = 8'hf0;
              seq_d[4] = lk_code;
              len_d    = EMIT_BREAK ? 3'd5 : 3'd2;
            end else begin
              seq_d[0] = lk_code;
              seq_d[1] = 8'hf0;
              seq_d[2] = lk_code;
              seq_d[3] = 8'h00;
              seq_d[4] = 8'h00;
              len_d    = EMIT_BREAK ? 3'd3 : 3'd1;
            end
          end
        end
      end
      SEND: begin
        if (bus.scan_ready) begin
          if (idx_q == len_q - 3'd1) begin
            state_d = IDLE;
          end else begin
            // Index advances on the transfer so the gap can simply return to SEND.
            idx_d = idx_q + 3'd1;
            if (GAP_CYCLES > 0) begin
              state_d = GAP;
              gap_d   = GAP_LAST;
            end
          end
        end
      end
      GAP: begin
        if (gap_q == 8'd0) state_d = SEND;
        else               gap_d   = gap_q - 8'd1;
      end
      DROP: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= 3'd0;
      idx_q   <= 3'd0;
      gap_q   <= 8'd0;
      for (int i = 0; i < 5; i++) seq_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      seq_q   <= seq_d;
    end
  end

  assign bus.key_ready  = (state_q == IDLE);
  assign bus.scan_valid = (state_q == SEND);
  assign bus.scan_code  = (state_q == SEND) ? seq_q[idx_q] : 8'h00;
  assign bus.unmapped   = (state_q == DROP);
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ascii_to_scancode.sv
// Scoreboarded bench for the Hack-code to PS/2 encoder: three parameterisations,
// byte-stream scoreboard with a reference decoder for closed-loop round trips.
module tb_ascii_to_scancode;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ascii_to_scancode_if if0 ();
  ascii_to_scancode_if if1 ();
  ascii_to_scancode_if if2 ();

  ascii_to_scancode #(.EMIT_BREAK(1'b1), .GAP_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  ascii_to_scancode #(.EMIT_BREAK(1'b0), .GAP_CYCLES(0)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  ascii_to_scancode #(.EMIT_BREAK(1'b1), .GAP_CYCLES(3)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

  int checks = 0;
  int passed = 0;

  logic [7:0] q_exp [$];
  logic [7:0] dec_q [$];

  // Reference mapping written straight from the key table.
  function automatic void spec_map(input logic [7:0] c, output bit ok, output bit ext, output logic [7:0] s);
    logic [79:0]  digits;
    logic [207:0] letters;
    logic [95:0]  fkeys;
    logic [79:0]  arrows;
    int           k;
    digits  = 80'h45_16_1e_26_25_2e_36_3d_3e_46;
    letters = 208'h1c_32_21_23_24_2b_34_33_43_3b_42_4b_3a_31_44_4d_15_2d_1b_2c_3c_2a_1d_22_35_1a;
    fkeys   = 96'h05_06_04_0c_03_0b_83_0a_01_09_78_07;
    arrows  = 80'h6b_75_74_72_6c_69_7d_7a_70_71;
    k   = int'(c);
    ok  = 1'b1;
    ext = 1'b0;
    s   = 8'h00;
    if (k >= 48 && k <= 57)        s = digits[8*(57-k) +: 8];
    else if (k >= 97 && k <= 122)  s = letters[8*(122-k) +: 8];
    else if (k >= 141 && k <= 152) s = fkeys[8*(152-k) +: 8];
    else if (k >= 130 && k <= 139) begin s = arrows[8*(139-k) +: 8]; ext = 1'b1; end
    else begin
      case (k)
        9: s = 8'h0d;   32: s = 8'h29;  39: s = 8'h52;  42: s = 8'h7c;  43: s = 8'h79;
        44: s = 8'h41;  45: s = 8'h4e;  46: s = 8'h49;  47: s = 8'h4a;  58: s = 8'h4c;
        61: s = 8'h55;  91: s = 8'h54;  92: s = 8'h5d;  93: s = 8'h5b;  96: s = 8'h0e;
        128: s = 8'h5a; 129: s = 8'h66; 140: s = 8'h76;
        default: ok = 1'b0;
      endcase
    end
  endfunction

  function automatic logic [7:0] decode_byte(input bit ext, input logic [7:0] s);
    bit ok, e;
    logic [7:0] b;
    for (int c = 1; c < 256; c++) begin
      spec_map(8'(c), ok, e, b);
      if (ok && e == ext && b == s) return 8'(c);
    end
    return 8'h00;
  endfunction

  // Scoreboard + hold-stability monitor + reference decoder on dut0's byte stream.
  bit         prev_hold = 1'b0;
  logic [7:0] prev_code = 8'h00;
  bit         d_ext = 1'b0;
  bit         d_brk = 1'b0;
  logic [7:0] mon_e;
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
      d_ext = 1'b0;
      d_brk = 1'b0;
    end else begin
      if (prev_hold) begin
        checks++;
        if (if0.scan_valid !== 1'b1 || if0.scan_code !== prev_code)
          $display("FAIL hold: valid=%b code=%h required valid=1 code=%h", if0.scan_valid, if0.scan_code, prev_code);
        else passed++;
      end
      prev_hold = if0.scan_valid && !if0.scan_ready;
      prev_code = if0.scan_code;
      if (if0.scan_valid && if0.scan_ready) begin
        checks++;
        if (q_exp.size() == 0) begin
          $display("FAIL unexpected_byte: got %h with nothing expected", if0.scan_code);
        end else begin
          mon_e = q_exp.pop_front();
          if (if0.scan_code !== mon_e) $display("FAIL byte: got %h required %h", if0.scan_code, mon_e);
          else begin passed++; $display("byte %h ok", if0.scan_code); end
        end
        if (if0.scan_code == 8'he0) d_ext = 1'b1;
        else if (if0.scan_code == 8'hf0) d_brk = 1'b1;
        else begin
          dec_q.push_back(d_brk ? 8'h00 : decode_byte(d_ext, if0.scan_code));
          d_ext = 1'b0;
          d_brk = 1'b0;
        end
      end
    end
  end

  task automatic send_key0(input logic [7:0] c);
    bit ok, ext;
    logic [7:0] s;
    int n;
    n = 0;
    while (if0.key_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin checks++; $display("FAIL ready_timeout: key_ready=%b required 1", if0.key_ready); end
    spec_map(c, ok, ext, s);
    if (ok) begin
      if (ext) q_exp.push_back(8'he0);
      q_exp.push_back(s);
      if (ext) q_exp.push_back(8'he0);
      q_exp.push_back(8'hf0);
      q_exp.push_back(s);
    end
    if0.key_valid = 1'b1;
    if0.key_code  = c;
    @(posedge clk); #1;
    if0.key_valid = 1'b0;
  endtask

  task automatic drain0();
    int n;
    n = 0;
    while ((q_exp.size() != 0 || if0.busy) && n < 500) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 500) $display("FAIL drain_timeout: %0d bytes outstanding, required 0", q_exp.size());
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({if0.key_ready, if0.scan_valid, if0.scan_code, if0.unmapped, if0.busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0})
      $display("FAIL reset_state: rdy=%b vld=%b code=%h unm=%b busy=%b required 1 0 00 0 0",
               if0.key_ready, if0.scan_valid, if0.scan_code, if0.unmapped, if0.busy);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [3] = '{8'h1c, 8'hf0, 8'h1c};
    dec_q.delete();
    send_key0(8'd97);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (if0.scan_valid !== 1'b1 || if0.scan_code !== exp_b[i] || if0.key_ready !== 1'b0)
        $display("FAIL basic_cycle%0d: vld=%b code=%h rdy=%b required 1 %h 0", i, if0.scan_valid, if0.scan_code, if0.key_ready, exp_b[i]);
      else passed++;
    end
    @(negedge clk);
    checks++;
    if (if0.scan_valid !== 1'b0 || if0.key_ready !== 1'b1)
      $display("FAIL basic_done: vld=%b rdy=%b required 0 1", if0.scan_valid, if0.key_ready);
    else passed++;
    @(posedge clk); #1;
    drain0();
    $display("key 97 sequence checked");
  endtask

  task automatic test_ext();
    send_key0(8'd131);
    drain0();
    if1.key_valid = 1'b1;
    if1.key_code  = 8'd131;
    @(posedge clk); #1;
    if1.key_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (if1.scan_valid !== 1'b1 || if1.scan_code !== 8'he0)
      $display("FAIL nobreak_b0: vld=%b code=%h required 1 e0", if1.scan_valid, if1.scan_code);
    else passed++;
    @(negedge clk);
    checks++;
    if (if1.scan_valid !== 1'b1 || if1.scan_code !== 8'h75)
      $display("FAIL nobreak_b1: vld=%b code=%h required 1 75", if1.scan_valid, if1.scan_code);
    else passed++;
    @(negedge clk);
    checks++;
    if (if1.scan_valid !== 1'b0 || if1.key_ready !== 1'b1)
      $display("FAIL nobreak_end: vld=%b rdy=%b required 0 1", if1.scan_valid, if1.key_ready);
    else passed++;
    @(posedge clk); #1;
    $display("key 131 checked with and without break");
  endtask

  task automatic test_backpressure();
    int n;
    if0.scan_ready = 1'b0;
    send_key0(8'd129);
    n = 0;
    while ((q_exp.size() != 0 || if0.busy) && n < 500) begin
      if0.scan_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    if0.scan_ready = 1'b1;
    checks++;
    if (n >= 500) $display("FAIL bp_timeout: %0d bytes outstanding, required 0", q_exp.size());
    else passed++;
    $display("key 129 under backpressure checked");
  endtask

  task automatic test_gap();
    bit         ev [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] ec [10] = '{8'h45, 8'h00, 8'h00, 8'h00, 8'hf0, 8'h00, 8'h00, 8'h00, 8'h45, 8'h00};
    if2.key_valid = 1'b1;
    if2.key_code  = 8'd48;
    @(posedge clk); #1;
    if2.key_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (if2.scan_valid !== ev[i] || (ev[i] && if2.scan_code !== ec[i]))
        $display("FAIL gap_cycle%0d: vld=%b code=%h required %b %h", i, if2.scan_valid, if2.scan_code, ev[i], ec[i]);
      else passed++;
    end
    checks++;
    if (if2.key_ready !== 1'b1) $display("FAIL gap_ready: rdy=%b required 1", if2.key_ready);
    else passed++;
    @(posedge clk); #1;
    $display("gap sequence for key 48 checked");
  endtask

  task automatic test_unmapped();
    logic [7:0] codes [2] = '{8'd200, 8'd0};
    for (int i = 0; i < 2; i++) begin
      send_key0(codes[i]);
      @(negedge clk);
      checks++;
      if (if0.unmapped !== 1'b1 || if0.scan_valid !== 1'b0 || if0.key_ready !== 1'b0)
        $display("FAIL unmapped_pulse key=%0d: unm=%b vld=%b rdy=%b required 1 0 0", codes[i], if0.unmapped, if0.scan_valid, if0.key_ready);
      else passed++;
      @(negedge clk);
      checks++;
      if (if0.unmapped !== 1'b0 || if0.scan_valid !== 1'b0 || if0.key_ready !== 1'b1)
        $display("FAIL unmapped_after key=%0d: unm=%b vld=%b rdy=%b required 0 0 1", codes[i], if0.unmapped, if0.scan_valid, if0.key_ready);
      else passed++;
      @(posedge clk); #1;
      $display("unmapped key %0d checked", codes[i]);
    end
    send_key0(8'd122);
    drain0();
  endtask

  task automatic test_reset_abort();
    send_key0(8'd136);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    if0.scan_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (if0.scan_valid !== 1'b0 || if0.key_ready !== 1'b1 || if0.busy !== 1'b0)
      $display("FAIL abort_state: vld=%b rdy=%b busy=%b required 0 1 0", if0.scan_valid, if0.key_ready, if0.busy);
    else passed++;
    checks++;
    if (q_exp.size() != 3) $display("FAIL abort_count: %0d bytes left, required 3", q_exp.size());
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    if0.scan_ready = 1'b1;
    q_exp.delete();
    dec_q.delete();
    $display("reset abort of key 136 checked");
  endtask

  task automatic test_closed_loop();
    bit ok, ext;
    logic [7:0] s;
    for (int c = 0; c < 256; c++) begin
      spec_map(8'(c), ok, ext, s);
      dec_q.delete();
      send_key0(8'(c));
      drain0();
      if (ok) begin
        checks++;
        if (dec_q.size() != 2 || dec_q[0] !== 8'(c) || dec_q[1] !== 8'h00)
          $display("FAIL roundtrip key=%0d: decoded %0d values first=%0d, required %0d then 0",
                   c, dec_q.size(), (dec_q.size() > 0) ? dec_q[0] : 8'hxx, c);
        else begin passed++; $display("roundtrip key %0d ok", c); end
      end
    end
  endtask

  initial begin
    if0.key_valid = 1'b0; if0.key_code = 8'h00; if0.scan_ready = 1'b1;
    if1.key_valid = 1'b0; if1.key_code = 8'h00; if1.scan_ready = 1'b1;
    if2.key_valid = 1'b0; if2.key_code = 8'h00; if2.scan_ready = 1'b1;
    test_reset();
    test_basic();
    test_ext();
    test_backpressure();
    test_gap();
    test_unmapped();
    test_reset_abort();
    test_closed_loop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
